// File: rtl/mem_resp_pkg.sv
// Shared types and default widths for the two-core memory request responder.
package mem_resp_pkg;

  localparam int ADRS_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  typedef enum logic {
    OP_LOAD,
    OP_STORE
  } op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic       o_gnt,
  output logic       o_any
);

  logic r_last;

  assign o_any = |i_req;
  assign o_gnt = (&i_req) ? ~r_last : i_req[1];

  // Reset to core 1 so core 0 wins the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              r_last <= 1'b1;
    else if (i_take && o_any) r_last <= o_gnt;
  end

endmodule

// File: rtl/mem_request_responder.sv
// Serves load/store requests from two cores onto one single-port memory,
// one transaction at a time, with four-phase request/valid handshakes.
module mem_request_responder
  import mem_resp_pkg::*;
#(
  parameter int ADRS_W = ADRS_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        rd_req,
  input  logic [ADRS_W-1:0] rd_adrs0,
  input  logic [ADRS_W-1:0] rd_adrs1,
  input  logic [1:0]        wr_req,
  input  logic [ADRS_W-1:0] wr_adrs0,
  input  logic [ADRS_W-1:0] wr_adrs1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        rd_valid,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic [1:0]        wr_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADRS_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            r_state, w_next;
  logic              r_core;
  op_t               r_op;
  logic [ADRS_W-1:0] r_adrs;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_rd_done, r_wr_done;
  logic [DATA_W-1:0] r_rd_data0, r_rd_data1;

  logic [1:0] w_elig_rd, w_elig_wr;
  logic       w_gnt, w_any, w_grant;

  // A completed request stays ineligible until its requester lowers it.
  assign w_elig_rd = rd_req & ~r_rd_done;
  assign w_elig_wr = wr_req & ~r_wr_done;
  assign w_grant   = (r_state == ST_IDLE) && w_any;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .i_req  (w_elig_rd | w_elig_wr),
    .i_take (w_grant),
    .o_gnt  (w_gnt),
    .o_any  (w_any)
  );

  // Latch the granted transaction; a store beats a load from the same core.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_core  <= 1'b0;
      r_op    <= OP_LOAD;
      r_adrs  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_core  <= w_gnt;
      r_wdata <= w_gnt ? wr_data1 : wr_data0;
      if (w_elig_wr[w_gnt]) begin
        r_op   <= OP_STORE;
        r_adrs <= w_gnt ? wr_adrs1 : wr_adrs0;
      end else begin
        r_op   <= OP_LOAD;
        r_adrs <= w_gnt ? rd_adrs1 : rd_adrs0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    rd_valid = '0;
    wr_valid = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_en = 1'b1;
        mem_we = (r_op == OP_STORE);
        w_next = (r_op == OP_STORE) ? ST_RESP : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (r_op == OP_STORE) wr_valid[r_core] = 1'b1;
        else                  rd_valid[r_core] = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign mem_adrs  = r_adrs;
  assign mem_wdata = r_wdata;

  // Done flags set by the valid pulse, cleared whenever the request is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_done <= '0;
      r_wr_done <= '0;
    end else begin
      r_rd_done <= rd_req & (r_rd_done | rd_valid);
      r_wr_done <= wr_req & (r_wr_done | wr_valid);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
    end else if (r_state == ST_CAPTURE) begin
      if (r_core) r_rd_data1 <= mem_rdata;
      else        r_rd_data0 <= mem_rdata;
    end
  end

  assign rd_data0 = r_rd_data0;
  assign rd_data1 = r_rd_data1;

endmodule

// File: tb/tb_mem_request_responder.sv
// Randomized and directed bench for mem_request_responder with a
// transaction-timeline reference model and a behavioural memory.
module tb_mem_request_responder;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [1:0]    rd_req, wr_req;
  logic [AW-1:0] rd_adrs0, rd_adrs1, wr_adrs0, wr_adrs1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [1:0]    rd_valid, wr_valid;
  logic [DW-1:0] rd_data0, rd_data1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adrs;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_request_responder #(.ADRS_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rd_req    (rd_req),
    .rd_adrs0  (rd_adrs0),
    .rd_adrs1  (rd_adrs1),
    .wr_req    (wr_req),
    .wr_adrs0  (wr_adrs0),
    .wr_adrs1  (wr_adrs1),
    .wr_data0  (wr_data0),
    .wr_data1  (wr_data1),
    .rd_valid  (rd_valid),
    .rd_data0  (rd_data0),
    .rd_data1  (rd_data1),
    .wr_valid  (wr_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_adrs  (mem_adrs),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] seed_val(input logic [AW-1:0] a);
    return 32'(a) * 32'd17;
  endfunction

  // Behavioural single-port memory: unwritten words hold adrs*17.
  logic [DW-1:0] emem [0:2047];
  bit            ewr  [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        emem[mem_adrs] <= mem_wdata;
        ewr[mem_adrs]  <= 1'b1;
      end else begin
        mem_rdata <= ewr[mem_adrs] ? emem[mem_adrs] : seed_val(mem_adrs);
      end
    end
  end

  // Reference model: a granted transaction at cycle N accesses memory at
  // N+1 and responds at N+2 (store) or N+3 (load).
  bit            m_pend, m_st, m_core, m_last;
  int            m_tacc;
  logic [AW-1:0] m_adrs;
  logic [DW-1:0] m_wd, m_rval;
  logic [DW-1:0] e_rd [2];
  bit   [1:0]    m_rdn, m_wdn;
  logic [DW-1:0] mm [0:2047];
  bit            mw [0:2047];
  int            cyc = 0, en_cnt = 0;
  int            rv_cnt [2];
  bit            log_on = 1'b0;
  int            vq [$];

  always @(negedge clk) begin
    logic [1:0] e_rv, e_wv, er, ew;
    logic       e_en, e_we;
    bit         idle, g;
    cyc++;
    if (mem_en) en_cnt++;
    rv_cnt[0] += int'(rd_valid[0]);
    rv_cnt[1] += int'(rd_valid[1]);
    if (!resetn) begin
      m_pend = 1'b0; m_rdn = '0; m_wdn = '0; m_last = 1'b1;
      e_rd[0] = '0;  e_rd[1] = '0;
      chk("reset_out", {rd_valid, wr_valid, mem_en, mem_we, mem_adrs, mem_wdata}, '0);
      chk("reset_rdata", {rd_data0, rd_data1}, '0);
    end else begin
      idle = !m_pend;
      e_en = 1'b0; e_we = 1'b0; e_rv = '0; e_wv = '0;
      if (m_pend) begin
        if (cyc == m_tacc) begin
          e_en = 1'b1;
          e_we = m_st;
          if (m_st) begin mm[m_adrs] = m_wd; mw[m_adrs] = 1'b1; end
          else m_rval = mw[m_adrs] ? mm[m_adrs] : seed_val(m_adrs);
        end
        if (m_st && cyc == m_tacc + 1) begin e_wv[m_core] = 1'b1; m_pend = 1'b0; end
        if (!m_st && cyc == m_tacc + 2) begin
          e_rv[m_core] = 1'b1; e_rd[m_core] = m_rval; m_pend = 1'b0;
        end
      end
      chk("ctl", {rd_valid, wr_valid, mem_en, mem_we}, {e_rv, e_wv, e_en, e_we});
      if (e_en) chk("mem_adrs", mem_adrs, m_adrs);
      if (e_we) chk("mem_wdata", mem_wdata, m_wd);
      chk("rd_data0", rd_data0, e_rd[0]);
      chk("rd_data1", rd_data1, e_rd[1]);
      if (log_on && (rd_valid | wr_valid) != 2'b00) vq.push_back(int'(rd_valid[1] | wr_valid[1]));
      er = rd_req & ~m_rdn;
      ew = wr_req & ~m_wdn;
      if (idle && (er | ew) != 2'b00) begin
        g      = ((er | ew) == 2'b11) ? !m_last : (er[1] | ew[1]);
        m_last = g;
        m_core = g;
        m_pend = 1'b1;
        m_tacc = cyc + 1;
        m_st   = ew[g];
        m_adrs = m_st ? (g ? wr_adrs1 : wr_adrs0) : (g ? rd_adrs1 : rd_adrs0);
        m_wd   = g ? wr_data1 : wr_data0;
      end
      m_rdn = rd_req & (m_rdn | e_rv);
      m_wdn = wr_req & (m_wdn | e_wv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_v(input string nm, input bit is_rd, input int c, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(is_rd ? rd_valid[c] : wr_valid[c]) && k < 40);
    chk({nm, "_seen"}, (is_rd ? rd_valid[c] : wr_valid[c]), 1'b1);
  endtask

  task automatic raise(input int i, input int o);
    logic [AW-1:0] a;
    a = ($urandom % 8 == 0) ? 11'h7FF : AW'($urandom_range(0, 7));
    if (o == 1) begin
      if (i == 0) begin wr_adrs0 = a; wr_data0 = $urandom; end
      else        begin wr_adrs1 = a; wr_data1 = $urandom; end
      wr_req[i] = 1'b1;
    end else begin
      if (i == 0) rd_adrs0 = a; else rd_adrs1 = a;
      rd_req[i] = 1'b1;
    end
  endtask

  initial begin
    int k, e0, r0, bad, n1;
    bit served [2][2];
    int hold   [2][2];
    bit dropped;
    resetn = 1'b0; rd_req = '0; wr_req = '0;
    rd_adrs0 = '0; rd_adrs1 = '0; wr_adrs0 = '0; wr_adrs1 = '0;
    wr_data0 = '0; wr_data1 = '0;
    rv_cnt[0] = 0; rv_cnt[1] = 0;
    repeat (3) tick();
    chk("rst_mem_en", mem_en, 1'b0);
    resetn = 1'b1;
    tick();

    // Simultaneous loads: core 0 wins the first tie, then core 1.
    rd_adrs0 = 11'h001; rd_adrs1 = 11'h002; rd_req = 2'b11;
    wait_v("dual_c0", 1'b1, 0, k);
    chk("dual_lat", k, 3);
    chk("dual_first", rd_valid, 2'b01);
    rd_req[0] = 1'b0;
    wait_v("dual_c1", 1'b1, 1, k);
    rd_req[1] = 1'b0;
    chk("dual_d0", rd_data0, 32'h11);
    chk("dual_d1", rd_data1, 32'h22);
    tick();

    // Store then load at the same address.
    wr_adrs0 = 11'h010; wr_data0 = 32'hDEADBEEF; wr_req[0] = 1'b1;
    wait_v("st", 1'b0, 0, k);
    chk("st_lat", k, 2);
    wr_req[0] = 1'b0;
    tick();
    rd_adrs0 = 11'h010; rd_req[0] = 1'b1;
    wait_v("ld", 1'b1, 0, k);
    chk("ld_lat", k, 3);
    chk("ld_data", rd_data0, 32'hDEADBEEF);
    rd_req[0] = 1'b0;
    tick();

    // Store and load raised together at the top address.
    wr_adrs0 = 11'h7FF; rd_adrs0 = 11'h7FF; wr_data0 = 32'hA5A55A5A;
    wr_req[0] = 1'b1; rd_req[0] = 1'b1;
    wait_v("both_st", 1'b0, 0, k);
    chk("both_st_lat", k, 2);
    wr_req[0] = 1'b0;
    wait_v("both_ld", 1'b1, 0, k);
    chk("both_ld_lat", k, 4);
    chk("both_ld_data", rd_data0, 32'hA5A55A5A);
    rd_req[0] = 1'b0;
    tick();

    // Request held high long after completion is served once.
    e0 = en_cnt; r0 = rv_cnt[1];
    rd_adrs1 = 11'h005; rd_req[1] = 1'b1;
    wait_v("hold", 1'b1, 1, k);
    repeat (20) tick();
    rd_req[1] = 1'b0;
    tick();
    chk("hold_en_cnt", en_cnt - e0, 1);
    chk("hold_rv_cnt", rv_cnt[1] - r0, 1);

    // Reset during CAPTURE aborts the load silently.
    rd_adrs0 = 11'h003; rd_req[0] = 1'b1;
    tick(); tick();
    resetn = 1'b0;
    #1;
    chk("abort_out", {rd_valid, wr_valid, mem_en, mem_we, mem_adrs, mem_wdata}, '0);
    r0 = rv_cnt[0];
    tick(); tick();
    rd_req[0] = 1'b0; resetn = 1'b1;
    repeat (3) tick();
    chk("abort_novalid", rv_cnt[0] - r0, 0);
    chk("abort_rdata0", rd_data0, '0);
    wr_adrs1 = 11'h020; wr_data1 = 32'h12345678; wr_req[1] = 1'b1;
    wait_v("after_abort", 1'b0, 1, k);
    chk("after_abort_lat", k, 2);
    wr_req[1] = 1'b0;
    tick();

    // Both cores always requesting: grants must alternate.
    log_on = 1'b1;
    raise(0, int'($urandom % 2)); raise(1, int'($urandom % 2));
    repeat (100) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        dropped = 1'b0;
        if (wr_valid[i]) begin wr_req[i] = 1'b0; dropped = 1'b1; end
        if (rd_valid[i]) begin rd_req[i] = 1'b0; dropped = 1'b1; end
        if (!dropped && !rd_req[i] && !wr_req[i]) raise(i, int'($urandom % 2));
      end
    end
    log_on = 1'b0;
    rd_req = '0; wr_req = '0;
    repeat (6) tick();
    bad = 0; n1 = 0;
    foreach (vq[j]) begin
      n1 += vq[j];
      if (j > 0 && vq[j] == vq[j-1]) bad++;
    end
    chk("alternate", bad, 0);
    chk("no_starve", (n1 >= 10 && vq.size() - n1 >= 10), 1'b1);

    // Random traffic with holds after completion and early drops.
    foreach (served[i, o]) begin served[i][o] = 1'b0; hold[i][o] = 0; end
    repeat (1500) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        for (int o = 0; o < 2; o++) begin
          bit rq, v;
          rq = (o == 1) ? wr_req[i] : rd_req[i];
          v  = (o == 1) ? wr_valid[i] : rd_valid[i];
          if (rq) begin
            if (v) begin
              served[i][o] = 1'b1;
              hold[i][o]   = int'($urandom_range(0, 3));
            end else if (served[i][o] ? (hold[i][o] == 0) : ($urandom % 40 == 0)) begin
              if (o == 1) wr_req[i] = 1'b0; else rd_req[i] = 1'b0;
            end else if (served[i][o]) begin
              hold[i][o]--;
            end
          end else if ($urandom % 3 == 0) begin
            raise(i, o);
            served[i][o] = 1'b0;
          end
        end
      end
    end
    rd_req = '0; wr_req = '0;
    repeat (8) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
